uart_tx_unit: RTL and testbench
===============================

// Module: uart_tx_unit
// PURPOSE
//   Serial UART transmitter used by uart_core on the TX side. It accepts one byte per handshake
//   and serialises it as start bit, 7 or 8 data bits (LSB first) and 1, 1.5 or 2 stop bits.
//   Contains its own 16x-oversampling baud tick generator driven by the ctrl-register divisor.
//   Sits between the TX FIFO read port and the tx pad.
// PARAMETERS
//   DVSR_WIDTH  11  width of baud divisor; baud = f_clk / (16*(dvsr+1))
//   SB_TICK_MAX 32  max stop-bit tick count (2 stop bits x 16)
// PORTS
//   clk           in   1           system clock; single clock domain
//   reset         in   1           synchronous, active-high
//   dvsr          in   DVSR_WIDTH  baud divisor (ctrl reg [10:0])
//   data_bits_7   in   1           1 = 7 data bits, 0 = 8 (ctrl reg bit 15)
//   stop_sel      in   2           00 = 1, 01 = 1.5, 10 = 2 stop bits, 11 = 1 stop bit (ctrl reg [14:13])
//   tx_start      in   1           request to send tx_din (FIFO not-empty)
//   tx_din        in   8           byte to send; bit 7 ignored in 7-bit mode
//   tx_ready      out  1           high in IDLE; frame accepted when tx_start & tx_ready
//   tx_done_tick  out  1           one-cycle pulse after last stop tick (FIFO read strobe)
//   tx            out  1           serial line, idle high
// BEHAVIOUR
//   - Reset: state=IDLE, tx=1, tx_ready=1, tx_done_tick=0, all counters 0. Takes effect next edge from any state.
//   - Accept (tx_start & tx_ready):
//     - Latch tx_din, dvsr, data_bits_7 and stop_sel.
//     - Clear baud counter; go to START; tx=0 from the following cycle.
//     - Config changes mid-frame have no effect until the next accept.
//   - Baud gen: counter 0..dvsr_latched; tick when count==dvsr_latched, then wrap to 0.
//     - First tick is dvsr+1 cycles after accept. dvsr=0 gives a tick every cycle.
//   - FSM IDLE->START->DATA->STOP->IDLE. s = 5-bit tick counter, n = 3-bit bit index.
//     - START: tx=0 for 16 ticks; on the 16th tick go to DATA with s=0, n=0.
//     - DATA: tx=shreg[0] for 16 ticks per bit, then shift right and n++.
//       Leave DATA after n==6 (7-bit mode) or n==7 (8-bit mode).
//     - STOP: tx=1 for 16, 24 or 32 ticks per stop_sel; on the last tick go to IDLE.
//   - tx_done_tick is registered: high for exactly the first IDLE cycle after STOP. Never asserted outside that cycle.
//   - Back-to-back frames: tx_start high in the done-tick cycle is accepted in that cycle.
//     The next start bit follows the stop bits with zero idle gap beyond 1 clk.
//   - tx_start while busy: ignored; no latching, no side effects.
//   - Frame length in clks = (dvsr+1) * 16 * (1 + N) + (dvsr+1) * stop_ticks, where N = 7 or 8.
//   - tx output is registered, so there are no glitches.
// TESTING
//   1. dvsr=3, 8 data, 1 stop, send 8'h33:
//      -> tx low 64 clks, then bits 1,1,0,0,1,1,0,0 at 64 clks each, high 64 clks.
//      -> One done tick 640 clks after accept.
//   2. dvsr=3, 7 data, 1.5 stop, send 8'hFB:
//      -> Data bits of 7'h7B, bit 7 never driven, stop held 96 clks.
//      -> Done tick at 608 clks.
//   3. dvsr=3, 8 data, 2 stop, tx_start held with 8'hAC then 8'h91:
//      -> Stop held 128 clks.
//      -> Second start bit begins 1 clk after the first done tick; exactly 2 done ticks.
//   4. Mid-frame: pulse tx_start with 8'h55 and change dvsr to 7 and stop_sel to 2.
//      -> Current frame is unchanged and 8'h55 is never sent.
//      -> The next frame uses 128-clk bits.
//   5. Assert reset during the DATA bit 3 phase:
//      -> The next cycle has tx=1, tx_ready=1 and no done tick; a new frame then sends correctly.
//   6. Loopback into the uart_core rx at dvsr=650 (9600 baud @100MHz), send 8'h32, 8'h57, 8'hA5:
//      -> The core read register returns the same values in order.

Source files
------------

// File: rtl/uart_tx_if.sv
// Handshake and configuration bundle between the TX FIFO/ctrl side and uart_tx_unit.
interface uart_tx_if #(
  parameter int DVSR_WIDTH = 11
);
  logic [DVSR_WIDTH-1:0] dvsr;
  logic                  data_bits_7;
  logic [1:0]            stop_sel;
  logic                  tx_start;
  logic [7:0]            tx_din;
  logic                  tx_ready;
  logic                  tx_done_tick;
  logic                  tx;

  // Producer side: FIFO read port plus control register fields.
  modport master (
    output dvsr, data_bits_7, stop_sel, tx_start, tx_din,
    input  tx_ready, tx_done_tick, tx
  );

  // Transmitter side.
  modport slave (
    input  dvsr, data_bits_7, stop_sel, tx_start, tx_din,
    output tx_ready, tx_done_tick, tx
  );
endinterface

// File: rtl/uart_tx_unit.sv
// UART transmitter: start bit, 7/8 data bits LSB first, 1/1.5/2 stop bits,
// with a private 16x-oversampling baud tick generator.
module uart_tx_unit #(
  parameter int DVSR_WIDTH  = 11,
  parameter int SB_TICK_MAX = 32
) (
  input  logic clk,
  input  logic reset,
  uart_tx_if.slave bus
);

  localparam int S_W = $clog2(SB_TICK_MAX);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [DVSR_WIDTH-1:0] dvsr_q;
  logic [DVSR_WIDTH-1:0] baud_cnt;
  logic                  data_bits_7_q;
  logic [1:0]            stop_sel_q;
  logic [7:0]            shreg;
  logic [S_W-1:0]        s;
  logic [2:0]            n;
  logic                  tx_q;
  logic                  ready_q;
  logic                  done_q;

  logic                  tick;
  logic                  last_bit_tick;
  logic                  last_data_bit;
  logic [S_W-1:0]        stop_last;

  assign tick          = (baud_cnt == dvsr_q);
  assign last_bit_tick = (s == S_W'(15));
  assign last_data_bit = (n == (data_bits_7_q ? 3'd6 : 3'd7));

  // Final stop tick index for the latched stop-bit selection.
  always_comb begin
    stop_last = S_W'(15);
    case (stop_sel_q)
      2'b01:   stop_last = S_W'(23);
      2'b10:   stop_last = S_W'(31);
      default: stop_last = S_W'(15);
    endcase
  end

  // Baud counter: idles at zero so the first tick lands dvsr+1 cycles after accept.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <=, so every register
    // samples the pre-edge values and block ordering never matters.
    if (reset) begin
      baud_cnt <= '0;
    end else if (state == IDLE || tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // Frame FSM with registered tx, ready and done outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dvsr_q        <= '0;
      data_bits_7_q <= 1'b0;
      stop_sel_q    <= 2'b00;
      shreg         <= '0;
      s             <= '0;
      n             <= '0;
      tx_q          <= 1'b1;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      // NOTE: default assignment makes done a single-cycle pulse; only the
      // STOP->IDLE transition below overrides it.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_start && ready_q) begin
            dvsr_q        <= bus.dvsr;
            data_bits_7_q <= bus.data_bits_7;
            stop_sel_q    <= bus.stop_sel;
            shreg         <= bus.tx_din;
            s             <= '0;
            n             <= '0;
            tx_q          <= 1'b0;
            ready_q       <= 1'b0;
            state         <= START;
          end
        end
        START: begin
          if (tick) begin
            if (last_bit_tick) begin
              s     <= '0;
              n     <= '0;
              tx_q  <= shreg[0];
              state <= DATA;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (last_bit_tick) begin
              s <= '0;
              if (last_data_bit) begin
                tx_q  <= 1'b1;
                state <= STOP;
              end else begin
                shreg <= shreg >> 1;
                tx_q  <= shreg[1];
                n     <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s == stop_last) begin
              s       <= '0;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
              state   <= IDLE;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_ready     = ready_q;
  assign bus.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit: table of configured frames, hand-written
// corner sequences and randomized frames, all checked against a per-cycle frame model.
module tb_uart_tx_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_tx_if #(.DVSR_WIDTH(11)) bus ();

  uart_tx_unit #(.DVSR_WIDTH(11), .SB_TICK_MAX(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int stop_ticks(input logic [1:0] ss);
    case (ss)
      2'b01:   return 24;
      2'b10:   return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int frame_len(input int d, input logic db7, input logic [1:0] ss);
    int nb = db7 ? 7 : 8;
    return 16 * (d + 1) * (1 + nb) + (d + 1) * stop_ticks(ss);
  endfunction

  // Line level c cycles after the accept edge.
  function automatic logic exp_tx(input int c, input logic [7:0] din, input int d,
                                  input logic db7, input logic [1:0] ss);
    int bt = 16 * (d + 1);
    int nb = db7 ? 7 : 8;
    int i;
    if (c >= frame_len(d, db7, ss)) return 1'b1;
    if (c < bt) return 1'b0;
    i = c / bt - 1;
    if (i < nb) return din[i];
    return 1'b1;
  endfunction

  // ---------------- frame driver / checker ----------------
  // Entered on a negedge with the unit idle; leaves on the negedge of the done-tick cycle.
  task automatic run_frame(input string tag, input logic [7:0] din, input int d,
                           input logic db7, input logic [1:0] ss, input int exp_len,
                           input bit hold, input int dist_at, input int abort_at);
    int len = frame_len(d, db7, ss);
    int bad_tx = -1, bad_rdy = -1, done_cnt = 0, done_at = -1;
    bit aborted = 0;
    bus.tx_din      = din;
    bus.dvsr        = 11'(d);
    bus.data_bits_7 = db7;
    bus.stop_sel    = ss;
    bus.tx_start    = 1'b1;
    check({tag, " ready at accept"}, int'(bus.tx_ready), 1);
    if (exp_len >= 0) check({tag, " frame length"}, len, exp_len);
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) bus.tx_start = 1'b0;
      if (bus.tx !== exp_tx(c, din, d, db7, ss) && bad_tx < 0) bad_tx = c;
      if (bus.tx_ready !== (c >= len) && bad_rdy < 0) bad_rdy = c;
      if (bus.tx_done_tick === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (c == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        check({tag, " tx after reset"}, int'(bus.tx), 1);
        check({tag, " ready after reset"}, int'(bus.tx_ready), 1);
        check({tag, " no done after reset"}, int'(bus.tx_done_tick), 0);
        reset = 1'b0;
        aborted = 1;
        break;
      end
      if (c == dist_at) begin
        bus.tx_start = 1'b1;
        bus.tx_din   = 8'h55;
        bus.dvsr     = 11'd7;
        bus.stop_sel = 2'b10;
      end
      if (c == dist_at + 1) bus.tx_start = 1'b0;
    end
    check({tag, " first bad tx cycle"}, bad_tx, -1);
    check({tag, " first bad ready cycle"}, bad_rdy, -1);
    if (!aborted) begin
      check({tag, " done count"}, done_cnt, 1);
      check({tag, " done cycle"}, done_at, len);
    end else begin
      check({tag, " done count before reset"}, done_cnt, 0);
    end
  endtask

  task automatic idle_check(input string tag, input int ncyc);
    int bad = 0;
    bus.tx_start = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_done_tick !== 1'b0) bad++;
    end
    check({tag, " idle cycles wrong"}, bad, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] din;
    int         d;
    logic       db7;
    logic [1:0] ss;
    int         len;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'h33, 3, 1'b0, 2'b00, 640};
    vecs[1] = '{8'hFB, 3, 1'b1, 2'b01, 608};
    vecs[2] = '{8'hAC, 3, 1'b0, 2'b10, 704};
    vecs[3] = '{8'h5A, 0, 1'b0, 2'b11, 160};
    vecs[4] = '{8'h81, 1, 1'b1, 2'b00, 288};
    vecs[5] = '{8'hC3, 0, 1'b1, 2'b10, 160};

    reset           = 1'b1;
    bus.tx_start    = 1'b0;
    bus.tx_din      = 8'h00;
    bus.dvsr        = 11'd3;
    bus.data_bits_7 = 1'b0;
    bus.stop_sel    = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset tx", int'(bus.tx), 1);
    check("reset ready", int'(bus.tx_ready), 1);
    check("reset done", int'(bus.tx_done_tick), 0);
    idle_check("post reset", 4);

    for (int v = 0; v < 6; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].din, vecs[v].d, vecs[v].db7,
                vecs[v].ss, vecs[v].len, 1'b0, -1, -1);
      idle_check($sformatf("vec%0d", v), 3);
    end

    // Back-to-back with tx_start held throughout: second start bit right after the done cycle.
    run_frame("b2b first", 8'hAC, 3, 1'b0, 2'b10, 704, 1'b1, -1, -1);
    run_frame("b2b second", 8'h91, 3, 1'b0, 2'b10, 704, 1'b0, -1, -1);
    idle_check("b2b end", 3);

    // Busy pulse with config change mid-frame: ignored; next frame uses 128-clk bits.
    run_frame("midframe", 8'h0F, 3, 1'b0, 2'b00, 640, 1'b0, 64 * 2 + 5, -1);
    idle_check("midframe no 55", 20);
    run_frame("slow frame", 8'hE1, 7, 1'b0, 2'b10, 1408, 1'b0, -1, -1);
    idle_check("slow frame", 3);

    // Reset during data bit 3, then a clean frame.
    run_frame("abort", 8'h5C, 3, 1'b0, 2'b00, 640, 1'b0, -1, 64 * 4 + 10);
    idle_check("abort recovery", 5);
    run_frame("after abort", 8'h3A, 3, 1'b0, 2'b00, 640, 1'b0, -1, -1);
    idle_check("after abort", 3);

    // Randomized frames, some back-to-back.
    for (int r = 0; r < 8; r++) begin
      logic [7:0] din;
      int         d;
      logic       db7;
      logic [1:0] ss;
      bit         hold;
      din  = 8'($urandom);
      d    = int'($urandom_range(0, 3));
      db7  = 1'($urandom_range(0, 1));
      ss   = 2'($urandom_range(0, 3));
      hold = (r < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame($sformatf("rand%0d", r), din, d, db7, ss, -1, hold, -1, -1);
      if (!hold) idle_check($sformatf("rand%0d", r), 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
